sw_cmd_decoder: RTL and testbench
=================================

// Module: sw_cmd_decoder
// PURPOSE
//  Turns N_SW raw one-hot command switches into debounced, single-shot opcodes for the controller.
//  Pipeline: 2-flop synchroniser, then vector debounce, then one-hot classifier, then issue FSM with valid/ready handshake.
//  Sits between the board switch pins and the controller command input.
//  Generalises the combinational switch decoder: parametrised width, debounce, one command per press, backpressure, multi-hot error.
// PARAMETERS
//  N_SW          4    number of command switches; >=2
//  OP_W          3    opcode width; 2**OP_W must be > N_SW (elaboration error otherwise)
//  DEBOUNCE_CYC  16   cycles the synchronised vector must be unchanged before it is accepted; >=2
//  CNT_W         5    debounce counter width; 2**CNT_W must be > DEBOUNCE_CYC
// PORTS
//  clk         in   1      system clock; all state updates on posedge
//  reset       in   1      synchronous, active-high reset
//  sw          in   N_SW   raw switch inputs, asynchronous
//  cmd_ready   in   1      controller accepts the command this cycle
//  cmd_valid   out  1      command opcode valid; held until accepted
//  cmd_opcode  out  OP_W   opcode; stable while cmd_valid=1; 0 when idle
//  busy        out  1      high whenever FSM is not IDLE
//  err_multi   out  1      one-cycle pulse: debounced vector became multi-hot while IDLE
//  sw_stable   out  N_SW   current debounced switch vector
// BEHAVIOUR
//  Reset: sync flops, sw_stable, counter, cmd_opcode = 0; cmd_valid, busy, err_multi = 0; FSM = IDLE.
//  Synchroniser: sync1 <= sw; sync2 <= sync1. No logic between the flops.
//  Debounce acts on the whole vector, not per bit:
//    - if sync2 != sync2_prev or sync2 == sw_stable: cnt <= 0
//    - else if cnt == DEBOUNCE_CYC-1: sw_stable <= sync2, cnt <= 0
//    - else cnt <= cnt+1
//    - latency: sw constant from before edge 0 -> sw_stable changes after edge DEBOUNCE_CYC+2
//    - glitch shorter than DEBOUNCE_CYC cycles: sw_stable does not change
//  Classifier (combinational on sw_stable):
//    - exactly bit i set: code = N_SW - i (MSB -> 1, bit0 -> N_SW)
//    - all zero: idle
//    - >1 bit set: multi
//  FSM states IDLE, ISSUE, WAIT_REL:
//    - IDLE: one-hot -> latch code into cmd_opcode, cmd_valid<=1, go ISSUE.
//      Multi, on the first cycle it is seen -> err_multi=1 for one cycle, go WAIT_REL. Zero -> stay.
//    - ISSUE: cmd_valid and cmd_opcode held regardless of sw_stable changes.
//      cmd_ready=1 -> handshake completes this edge; cmd_valid<=0, cmd_opcode<=0, go WAIT_REL.
//    - WAIT_REL: stay until sw_stable == 0, then IDLE. Gives one command per press; holding a switch never re-issues.
//  cmd_valid rises after edge DEBOUNCE_CYC+3 relative to a clean press. cmd_ready already high -> valid lasts exactly 1 cycle.
//  cmd_ready while cmd_valid=0 is ignored.
//  busy = (state != IDLE), registered with the state.
//  Release during ISSUE: command still delivered. FSM then passes WAIT_REL to IDLE on the next cycle after acceptance.
//  New one-hot press during WAIT_REL: ignored until full release.
//  Reset mid-ISSUE: pending command dropped, no handshake, all outputs to reset values next cycle.
//  A switch still held when reset deasserts is debounced again and issues a fresh command.
// TESTING
//  1 reset 3 cycles, sw=0 -> all outputs 0, busy=0 for 50 cycles.
//  2 N_SW=4, DEBOUNCE_CYC=16, cmd_ready=1, sw=4'b0100 held from edge 0
//    -> cmd_valid=1, opcode=3'd2 only after edge 19 (exactly 1 cycle).
//    -> no further valid while held; release -> busy drops 19 cycles after release.
//  3 sw=4'b0001 pulses 10 cycles on/5 off, repeated, then held -> no command during bouncing; exactly one opcode=3'd4 after the hold settles.
//  4 sw=4'b1010 held -> err_multi one-cycle pulse, cmd_valid never asserts, busy until sw=0 debounced.
//  5 cmd_ready=0, sw=4'b1000 pressed then released -> cmd_valid=1, opcode=3'd1 held 30+ cycles.
//    -> cmd_ready=1 for one cycle -> valid drops, single transfer counted.
//  6 reset asserted for 1 cycle during ISSUE with sw=4'b0010 still held -> valid drops.
//    -> opcode=3'd3 re-issued 20 cycles after reset release (DEBOUNCE_CYC+3 + 1 clean).

Source files
------------

// File: rtl/sw_cmd_decoder.sv
// ---------------------------------------------------------------------------
// sw_cmd_decoder
//
// Turns N_SW raw one-hot command switches into debounced, single-shot
// opcodes for the controller. Pipeline:
//   2-flop synchroniser -> whole-vector debounce -> one-hot classifier
//   -> issue FSM with valid/ready handshake.
//
// Ports
//   clk         in   1      system clock, all state updates on posedge
//   reset       in   1      synchronous, active-high reset
//   sw          in   N_SW   raw switch inputs (asynchronous)
//   cmd_ready   in   1      controller accepts the command this cycle
//   cmd_valid   out  1      opcode valid, held until accepted
//   cmd_opcode  out  OP_W   opcode, stable while cmd_valid=1, 0 when idle
//   busy        out  1      FSM is not IDLE
//   err_multi   out  1      one-cycle pulse: debounced vector went multi-hot
//                           while IDLE
//   sw_stable   out  N_SW   current debounced switch vector
//
// Opcode mapping: bit i alone -> N_SW - i (MSB -> 1, bit 0 -> N_SW).
// ---------------------------------------------------------------------------
module sw_cmd_decoder #(
  parameter int N_SW         = 4,
  parameter int OP_W         = 3,
  parameter int DEBOUNCE_CYC = 16,
  parameter int CNT_W        = 5
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_SW-1:0] sw,
  input  logic            cmd_ready,
  output logic            cmd_valid,
  output logic [OP_W-1:0] cmd_opcode,
  output logic            busy,
  output logic            err_multi,
  output logic [N_SW-1:0] sw_stable
);

  // Parameter sanity: opcode 0 is reserved for "idle", so codes 1..N_SW
  // must fit, and the debounce counter must reach DEBOUNCE_CYC-1.
  generate
    if ((2 ** OP_W) <= N_SW) begin : g_bad_op_w
      $error("sw_cmd_decoder: 2**OP_W must be greater than N_SW");
    end
    if ((2 ** CNT_W) <= DEBOUNCE_CYC) begin : g_bad_cnt_w
      $error("sw_cmd_decoder: 2**CNT_W must be greater than DEBOUNCE_CYC");
    end
    if (N_SW < 2 || DEBOUNCE_CYC < 2) begin : g_bad_size
      $error("sw_cmd_decoder: N_SW and DEBOUNCE_CYC must be >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ISSUE    = 2'd1,
    ST_WAIT_REL = 2'd2
  } state_t;

  // -------------------------------------------------------------------------
  // Synchroniser and debounce registers
  // -------------------------------------------------------------------------
  logic [N_SW-1:0]  sync1_q;
  logic [N_SW-1:0]  sync2_q;
  logic [N_SW-1:0]  sync2_prev_q;
  logic [N_SW-1:0]  sw_stable_q;
  logic [N_SW-1:0]  sw_stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Debounce works on the whole vector: any change in the synchronised
  // vector restarts the count, and nothing counts while it already matches
  // the accepted value.
  always_comb begin
    sw_stable_d = sw_stable_q;
    cnt_d       = cnt_q;
    if ((sync2_q != sync2_prev_q) || (sync2_q == sw_stable_q)) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYC - 1)) begin
      sw_stable_d = sync2_q;
      cnt_d       = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      sync2_prev_q <= '0;
      sw_stable_q  <= '0;
      cnt_q        <= '0;
    end else begin
      sync1_q      <= sw;
      sync2_q      <= sync1_q;
      sync2_prev_q <= sync2_q;
      sw_stable_q  <= sw_stable_d;
      cnt_q        <= cnt_d;
    end
  end

  // -------------------------------------------------------------------------
  // Classifier on the debounced vector
  // -------------------------------------------------------------------------
  logic [OP_W-1:0] bit_code [N_SW];
  logic [OP_W-1:0] code;
  logic            is_zero;
  logic            is_onehot;
  logic            is_multi;

  genvar gi;
  generate
    for (gi = 0; gi < N_SW; gi++) begin : g_code
      assign bit_code[gi] = sw_stable_q[gi] ? OP_W'(N_SW - gi) : '0;
    end
  endgenerate

  // OR of the per-bit codes is only meaningful when exactly one bit is set;
  // the FSM only consumes it in that case.
  always_comb begin
    code = '0;
    for (int i = 0; i < N_SW; i++) begin
      code = code | bit_code[i];
    end
  end

  assign is_zero   = (sw_stable_q == '0);
  assign is_onehot = !is_zero &&
                     ((sw_stable_q & (sw_stable_q - N_SW'(1))) == '0);
  assign is_multi  = !is_zero && !is_onehot;

  // -------------------------------------------------------------------------
  // Issue FSM
  // -------------------------------------------------------------------------
  state_t          state_q;
  state_t          state_d;
  logic            cmd_valid_q;
  logic            cmd_valid_d;
  logic [OP_W-1:0] cmd_opcode_q;
  logic [OP_W-1:0] cmd_opcode_d;
  logic            err_multi_q;
  logic            err_multi_d;
  logic            busy_q;

  always_comb begin
    state_d      = state_q;
    cmd_valid_d  = cmd_valid_q;
    cmd_opcode_d = cmd_opcode_q;
    err_multi_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (is_onehot) begin
          cmd_opcode_d = code;
          cmd_valid_d  = 1'b1;
          state_d      = ST_ISSUE;
        end else if (is_multi) begin
          // Leaving IDLE immediately makes the error a single-cycle pulse.
          err_multi_d = 1'b1;
          state_d     = ST_WAIT_REL;
        end
      end
      ST_ISSUE: begin
        // Opcode is frozen here; switch activity cannot alter it.
        if (cmd_ready) begin
          cmd_valid_d  = 1'b0;
          cmd_opcode_d = '0;
          state_d      = ST_WAIT_REL;
        end
      end
      ST_WAIT_REL: begin
        // One command per press: wait for a full debounced release.
        if (is_zero) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        cmd_valid_d  = 1'b0;
        cmd_opcode_d = '0;
        state_d      = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cmd_valid_q  <= 1'b0;
      cmd_opcode_q <= '0;
      err_multi_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_valid_q  <= cmd_valid_d;
      cmd_opcode_q <= cmd_opcode_d;
      err_multi_q  <= err_multi_d;
      busy_q       <= (state_d != ST_IDLE);
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = cmd_opcode_q;
  assign busy       = busy_q;
  assign err_multi  = err_multi_q;
  assign sw_stable  = sw_stable_q;

endmodule

// File: tb/tb_sw_cmd_decoder.sv
// ---------------------------------------------------------------------------
// tb_sw_cmd_decoder
//
// Self-checking bench for sw_cmd_decoder (N_SW=4, DEBOUNCE_CYC=16).
// A behavioural model built from the switch history and a command/release
// view of the protocol is compared against every DUT output each cycle.
// Directed sequences and a segment table cover the timing corner cases,
// followed by a randomized stretch.
// ---------------------------------------------------------------------------
module tb_sw_cmd_decoder;

  localparam int N_SW  = 4;
  localparam int OP_W  = 3;
  localparam int DEB   = 16;
  localparam int CNT_W = 5;

  logic            clk = 1'b0;
  logic            reset;
  logic [N_SW-1:0] sw;
  logic            cmd_ready;
  logic            cmd_valid;
  logic [OP_W-1:0] cmd_opcode;
  logic            busy;
  logic            err_multi;
  logic [N_SW-1:0] sw_stable;

  always #5 clk = ~clk;

  sw_cmd_decoder #(
    .N_SW(N_SW), .OP_W(OP_W), .DEBOUNCE_CYC(DEB), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .sw(sw), .cmd_ready(cmd_ready),
    .cmd_valid(cmd_valid), .cmd_opcode(cmd_opcode), .busy(busy),
    .err_multi(err_multi), .sw_stable(sw_stable)
  );

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int n_xfer = 0;
  int n_errp = 0;
  logic [OP_W-1:0] last_op = '0;

  // ---------------- reference model ----------------
  // hist[0] is the switch sample taken at the latest edge; hist[k] is k edges older.
  logic [N_SW-1:0] hist [DEB+3];
  logic [N_SW-1:0] m_stable = '0;
  logic            m_valid = 1'b0;
  logic            m_rel = 1'b0;   // a command or error happened; waiting for release
  logic            m_err = 1'b0;
  logic [OP_W-1:0] m_op = '0;

  function automatic logic [OP_W-1:0] code_of(input logic [N_SW-1:0] v);
    for (int i = 0; i < N_SW; i++) begin
      if (v[i]) return OP_W'(N_SW - i);
    end
    return '0;
  endfunction

  task automatic model_edge();
    logic [N_SW-1:0] seen;
    logic            run_ok;
    seen = m_stable;
    if (reset) begin
      for (int i = 0; i < DEB + 3; i++) hist[i] = '0;
      m_stable = '0; m_valid = 1'b0; m_rel = 1'b0; m_err = 1'b0; m_op = '0;
      return;
    end
    for (int i = DEB + 2; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = sw;
    // A value is accepted once it has been seen DEB+1 times in a row at the
    // synchroniser output (two samples behind the pins).
    run_ok = 1'b1;
    for (int i = 3; i <= DEB + 2; i++) begin
      if (hist[i] != hist[2]) run_ok = 1'b0;
    end
    if (run_ok && hist[2] != m_stable) m_stable = hist[2];
    m_err = 1'b0;
    if (m_valid) begin
      if (cmd_ready) begin
        m_valid = 1'b0; m_op = '0; m_rel = 1'b1;
      end
    end else if (m_rel) begin
      if (seen == '0) m_rel = 1'b0;
    end else if ($countones(seen) == 1) begin
      m_valid = 1'b1; m_op = code_of(seen);
    end else if (seen != '0) begin
      m_err = 1'b1; m_rel = 1'b1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  // One clock: log a handshake, advance model with DUT, compare on the falling edge.
  task automatic step();
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1 && reset === 1'b0) begin
      n_xfer++;
      last_op = cmd_opcode;
      $display("xfer opcode=%0d cycle=%0d", cmd_opcode, cyc);
    end
    if (err_multi === 1'b1) n_errp++;
    @(posedge clk);
    model_edge();
    cyc++;
    @(negedge clk);
    check("per_cycle_outputs",
          32'({cmd_valid, cmd_opcode, busy, err_multi, sw_stable}),
          32'({m_valid, m_op, (m_valid | m_rel), m_err, m_stable}));
  endtask

  // ---------------- directed segment table ----------------
  typedef struct {
    logic [N_SW-1:0] sw;
    logic            ready;
    int              cycles;
    int              exp_xfer;
    int              exp_err;
    logic [OP_W-1:0] exp_op;
  } seg_t;

  seg_t tbl[$];

  int first;
  int nvalid;
  int x0;
  int e0;
  logic flag;
  logic [OP_W-1:0] op_seen;

  initial begin
    // bounce 10 on / 5 off, then a settled hold -> one opcode 4
    for (int r = 0; r < 3; r++) begin
      tbl.push_back('{4'b0001, 1'b1, 10, 0, 0, 3'd0});
      tbl.push_back('{4'b0000, 1'b1, 5, 0, 0, 3'd0});
    end
    tbl.push_back('{4'b0001, 1'b1, 60, 1, 0, 3'd4});
    tbl.push_back('{4'b0000, 1'b1, 40, 0, 0, 3'd0});
    // multi-hot -> one error pulse, no command
    tbl.push_back('{4'b1010, 1'b1, 60, 0, 1, 3'd0});
    tbl.push_back('{4'b0000, 1'b1, 40, 0, 0, 3'd0});
    tbl.push_back('{4'b0010, 1'b1, 40, 1, 0, 3'd3});
    tbl.push_back('{4'b0000, 1'b1, 30, 0, 0, 3'd0});
    tbl.push_back('{4'b1000, 1'b1, 40, 1, 0, 3'd1});
    tbl.push_back('{4'b0000, 1'b1, 30, 0, 0, 3'd0});

    reset = 1'b1; sw = '0; cmd_ready = 1'b0;
    repeat (3) step();
    reset = 1'b0;

    // Quiet after reset
    flag = 1'b0;
    for (int k = 0; k < 50; k++) begin
      step();
      if (busy !== 1'b0 || cmd_valid !== 1'b0 || err_multi !== 1'b0) flag = 1'b1;
    end
    check("t1_quiet_50_cycles", 32'(flag), 32'd0);
    check("t1_outputs_zero", 32'({cmd_valid, cmd_opcode, busy, err_multi, sw_stable}), 32'd0);

    // Clean press with ready high: valid only after edge 19, one cycle
    cmd_ready = 1'b1; sw = 4'b0100;
    first = -1; nvalid = 0; x0 = n_xfer; op_seen = '0;
    for (int k = 0; k < 60; k++) begin
      step();
      if (cmd_valid === 1'b1) begin
        nvalid++;
        if (first < 0) begin first = k; op_seen = cmd_opcode; end
      end
    end
    check("t2_valid_first_edge", 32'(first), 32'd19);
    check("t2_opcode", 32'(op_seen), 32'd2);
    check("t2_valid_cycles", 32'(nvalid), 32'd1);
    check("t2_transfers", 32'(n_xfer - x0), 32'd1);
    sw = '0; first = -1;
    for (int k = 0; k < 60; k++) begin
      step();
      if (busy === 1'b0 && first < 0) first = k;
    end
    check("t2_busy_drop_after_release", 32'(first), 32'd19);

    // Segment table
    foreach (tbl[i]) begin
      sw = tbl[i].sw; cmd_ready = tbl[i].ready;
      x0 = n_xfer; e0 = n_errp;
      for (int k = 0; k < tbl[i].cycles; k++) step();
      check($sformatf("seg%0d_transfers", i), 32'(n_xfer - x0), 32'(tbl[i].exp_xfer));
      check($sformatf("seg%0d_err_pulses", i), 32'(n_errp - e0), 32'(tbl[i].exp_err));
      if (tbl[i].exp_xfer > 0)
        check($sformatf("seg%0d_opcode", i), 32'(last_op), 32'(tbl[i].exp_op));
    end

    // Backpressure: press and release while ready low, valid held
    cmd_ready = 1'b0; sw = 4'b1000; nvalid = 0; x0 = n_xfer;
    for (int k = 0; k < 25; k++) begin step(); if (cmd_valid === 1'b1) nvalid++; end
    sw = '0;
    for (int k = 0; k < 35; k++) begin step(); if (cmd_valid === 1'b1) nvalid++; end
    check("t5_valid_held_30plus", 32'(nvalid >= 30), 32'd1);
    check("t5_opcode_held", 32'({cmd_valid, cmd_opcode}), 32'({1'b1, 3'd1}));
    check("t5_no_transfer_yet", 32'(n_xfer - x0), 32'd0);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    check("t5_single_transfer", 32'(n_xfer - x0), 32'd1);
    check("t5_valid_dropped", 32'({cmd_valid, cmd_opcode, busy}), 32'({1'b0, 3'd0, 1'b1}));
    step();
    check("t5_idle_after_wait_rel", 32'(busy), 32'd0);
    for (int k = 0; k < 5; k++) step();
    check("t5_still_single_transfer", 32'(n_xfer - x0), 32'd1);

    // Reset while a command is pending, switch still held
    cmd_ready = 1'b0; sw = 4'b0010; first = -1;
    for (int k = 0; k < 40; k++) begin
      step();
      if (cmd_valid === 1'b1 && first < 0) first = k;
    end
    check("t6_pending_before_reset", 32'(first), 32'd19);
    x0 = n_xfer;
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_outputs_after_reset",
          32'({cmd_valid, cmd_opcode, busy, err_multi, sw_stable}), 32'd0);
    cmd_ready = 1'b1; first = -1; op_seen = '0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (cmd_valid === 1'b1 && first < 0) begin first = k; op_seen = cmd_opcode; end
    end
    check("t6_reissue_edge", 32'(first), 32'd20);
    check("t6_reissue_opcode", 32'(op_seen), 32'd3);
    check("t6_one_transfer", 32'(n_xfer - x0), 32'd1);
    sw = '0;
    for (int k = 0; k < 30; k++) step();

    // Randomized stretch against the model
    for (int s = 0; s < 150; s++) begin
      case ($urandom_range(0, 3))
        0: sw = '0;
        1: sw = N_SW'(1) << $urandom_range(0, N_SW - 1);
        default: sw = N_SW'($urandom_range(0, (1 << N_SW) - 1));
      endcase
      cmd_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
      end
      for (int k = $urandom_range(1, 40); k > 0; k--) step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
